// File: rtl/div_radix2_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift {r, q} left, trial-subtract the divisor.
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch can form.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dsr};
        rem_next = shifted;
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: LO = quotient, HI = remainder.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_abs;
    logic             neg_q;
    logic             neg_r;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_abs_in;
    logic [WIDTH-1:0] dsr_abs_in;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // Two's-complement negation wraps, so the most negative value maps onto itself as unsigned.
    assign dvd_neg    = is_signed && dividend[WIDTH-1];
    assign dsr_neg    = is_signed && divisor[WIDTH-1];
    assign dvd_abs_in = dvd_neg ? -dividend : dividend;
    assign dsr_abs_in = dsr_neg ? -divisor : divisor;

    assign ready = (state == DIV_IDLE);
    assign valid = (state == DIV_DONE) && !cancel;

    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dsr      (dsr_abs),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // `last` marks the fix-up cycle. A zero divisor skips the iterations but still passes
    // through that cycle, so both paths share one result-write point.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            last      <= 1'b0;
            rem_r     <= '0;
            quo_r     <= '0;
            dsr_abs   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && !cancel) begin
                        state   <= DIV_RUN;
                        cnt     <= '0;
                        dsr_abs <= dsr_abs_in;
                        if (divisor == '0) begin
                            quo_r <= '1;
                            rem_r <= {1'b0, dividend};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            last  <= 1'b1;
                        end else begin
                            quo_r <= dvd_abs_in;
                            rem_r <= '0;
                            neg_q <= dvd_neg ^ dsr_neg;
                            neg_r <= dvd_neg;
                            last  <= 1'b0;
                        end
                    end
                end
                DIV_RUN: begin
                    if (cancel) begin
                        state <= DIV_IDLE;
                    end else if (last) begin
                        quotient  <= neg_q ? -quo_r : quo_r;
                        remainder <= neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
                        state     <= DIV_DONE;
                    end else begin
                        rem_r <= rem_next;
                        quo_r <= quo_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            last <= 1'b1;
                        end
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed corner cases plus random operands vs. an arithmetic model.
module tb_div_radix2;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         cancel = 1'b0;
    logic         ready;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;

    div_radix2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .ready     (ready),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend's sign.
    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge = first posedge after start is driven; latency counts edges after it.
    task automatic do_div(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int exp_lat;
        int lat;
        bit seen;
        model(sgn, a, b, eq, er);
        exp_lat = (b == 0) ? 1 : W + 1;
        @(negedge clk);
        check({tag, "_ready_before"}, W'(ready), W'(1));
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            if (valid) seen = 1;
            else begin
                tick();
                lat++;
            end
        end
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        tick();
        check({tag, "_valid_one_cycle"}, W'(valid), W'(0));
        check({tag, "_ready_after"}, W'(ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q_hold;
        logic [W-1:0] r_hold;
        int vcount;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_valid", W'(valid), W'(0));
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("rst_ready", W'(ready), W'(1));

        // Directed corner cases
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0);
        do_div("div_by0", 1'b1, 32'h8000_0005, 32'd0);
        do_div("div_minint_2", 1'b1, 32'h8000_0000, 32'd2);

        // Random operands, biased toward small divisors and occasional zero
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 15);
                1:       b = 32'h0;
                2:       b = -$urandom_range(1, 300);
                default: b = $urandom;
            endcase
            do_div($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b);
        end

        // start pulses during RUN are ignored; cancel at iteration 10 kills the op
        q_hold = quotient;
        r_hold = remainder;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) tick();
        check("run_ready_low", W'(ready), W'(0));
        @(negedge clk);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_ready", W'(ready), W'(1));
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("cancel_no_valid", W'(vcount), W'(0));
        check("cancel_q_held", quotient, q_hold);
        check("cancel_r_held", remainder, r_hold);
        do_div("after_cancel_9_3", 1'b0, 32'd9, 32'd3);

        // Reset mid-RUN at iteration 20
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        tick();
        start = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        resetn = 1'b0;
        tick();
        check("midrst_quotient", quotient, '0);
        check("midrst_remainder", remainder, '0);
        check("midrst_valid", W'(valid), W'(0));
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("midrst_ready", W'(ready), W'(1));
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("midrst_no_valid", W'(vcount), W'(0));

        // start together with cancel in IDLE is not accepted
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd0;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("startcancel_ready", W'(ready), W'(1));
        tick();
        check("startcancel_valid", W'(valid), W'(0));
        check("startcancel_q", quotient, '0);

        // cancel during DONE suppresses valid
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd20; divisor = 32'd0;
        tick();
        start = 1'b0;
        tick();
        cancel = 1'b1;
        #1;
        check("done_cancel_valid", W'(valid), W'(0));
        tick();
        cancel = 1'b0;
        check("done_cancel_ready", W'(ready), W'(1));
        check("done_cancel_valid_after", W'(valid), W'(0));

        do_div("final_divu", 1'b0, 32'd123456, 32'd789);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
